// File: rtl/digit_entry_validator.sv
// digit_entry_validator: collects NUM_DIGITS decimal key codes into binary and packed BCD and hands off one result
module digit_entry_validator #(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 2,
    parameter int VAL_W      = 7,
    parameter int CNT_W      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VAL_W-1:0]        out_value,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic                    out_error,
    output logic [CNT_W-1:0]        digit_count
);
    typedef enum logic [1:0] {COLLECT, DONE, ERROR} state_t;
    state_t                  r_state;
    logic                    r_valid, r_error;
    logic [VAL_W-1:0]        r_value;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [CNT_W-1:0]        r_count;
    logic                    w_accept, w_digit, w_last;
    logic [3:0]              w_d;
    assign in_ready    = (r_state == COLLECT) && !clear;
    assign w_accept    = in_valid && in_ready;
    assign w_digit     = in_data <= DATA_W'(9);
    assign w_d         = 4'(in_data);
    assign w_last      = r_count == CNT_W'(NUM_DIGITS - 1);
    assign out_valid   = r_valid;
    assign out_error   = r_error;
    assign out_value   = r_value;
    assign out_bcd     = r_bcd;
    assign digit_count = r_count;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= COLLECT;
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_value <= '0;
            r_bcd   <= '0;
            r_count <= '0;
        end else if (clear || (r_valid && out_ready)) begin
            r_state <= COLLECT;
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_value <= '0;
            r_bcd   <= '0;
            r_count <= '0;
        end else if (w_accept && w_digit) begin
            r_value <= r_value * VAL_W'(10) + VAL_W'(w_d);
            r_bcd   <= (4*NUM_DIGITS)'({r_bcd, w_d});
            r_count <= r_count + CNT_W'(1);
            r_state <= w_last ? DONE : COLLECT;
            r_valid <= w_last;
        end else if (w_accept) begin
            // partial value/bcd/count are kept so the consumer sees what was typed
            r_state <= ERROR;
            r_valid <= 1'b1;
            r_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_digit_entry_validator.sv
// tb_digit_entry_validator: checks a 2-digit and a 4-digit instance against a digit-list model
module tb_digit_entry_validator;
    logic clk = 0, reset = 1;
    logic cl [2], iv [2], ordy [2];
    logic [7:0] id [2];
    logic rdy [2], ov [2], oe [2];
    logic [6:0]  val0;
    logic [13:0] val1;
    logic [7:0]  bcd0;
    logic [15:0] bcd1;
    logic [1:0]  cnt0;
    logic [2:0]  cnt1;
    logic [31:0] aval [2], abcd [2], acnt [2];
    int checks = 0, errors = 0;
    int dq [2][$];
    bit m_done [2], m_err [2];
    int nd [2] = '{2, 4};
    int vw [2] = '{7, 14};

    always #5 clk = ~clk;

    digit_entry_validator #(.DATA_W(8), .NUM_DIGITS(2), .VAL_W(7), .CNT_W(2)) u0 (
        .clock(clk), .reset(reset), .clear(cl[0]), .in_valid(iv[0]), .in_data(id[0]),
        .in_ready(rdy[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_value(val0),
        .out_bcd(bcd0), .out_error(oe[0]), .digit_count(cnt0));
    digit_entry_validator #(.DATA_W(8), .NUM_DIGITS(4), .VAL_W(14), .CNT_W(3)) u1 (
        .clock(clk), .reset(reset), .clear(cl[1]), .in_valid(iv[1]), .in_data(id[1]),
        .in_ready(rdy[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_value(val1),
        .out_bcd(bcd1), .out_error(oe[1]), .digit_count(cnt1));

    assign aval[0] = 32'(val0);
    assign aval[1] = 32'(val1);
    assign abcd[0] = 32'(bcd0);
    assign abcd[1] = 32'(bcd1);
    assign acnt[0] = 32'(cnt0);
    assign acnt[1] = 32'(cnt1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_val(input int k);
        longint v = 0;
        foreach (dq[k][i]) v = v * 10 + dq[k][i];
        return 32'(v % (longint'(1) << vw[k]));
    endfunction

    function automatic logic [31:0] exp_bcd(input int k);
        logic [31:0] b = 0;
        foreach (dq[k][i]) b = (b << 4) | 32'(dq[k][i]);
        return b;
    endfunction

    // model: an entry is simply the list of digits typed so far plus done/error flags
    initial forever begin
        @(posedge clk or posedge reset);
        for (int k = 0; k < 2; k++) begin
            if (reset || cl[k] || ((m_done[k] || m_err[k]) && ordy[k])) begin
                dq[k].delete();
                m_done[k] = 0;
                m_err[k]  = 0;
            end else if (!(m_done[k] || m_err[k]) && iv[k]) begin
                if (id[k] <= 9) begin
                    dq[k].push_back(int'(id[k]));
                    if (dq[k].size() == nd[k]) m_done[k] = 1;
                end else m_err[k] = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(m_done[k] || m_err[k]));
            chk($sformatf("out_error%0d", k), 32'(oe[k]), 32'(m_err[k]));
            chk($sformatf("in_ready%0d", k), 32'(rdy[k]), 32'(!(m_done[k] || m_err[k]) && !cl[k]));
            chk($sformatf("out_value%0d", k), aval[k], exp_val(k));
            chk($sformatf("out_bcd%0d", k), abcd[k], exp_bcd(k));
            chk($sformatf("digit_count%0d", k), acnt[k], 32'(dq[k].size()));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic key(input int k, input logic [7:0] c);
        iv[k] = 1;
        id[k] = c;
        step();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cl[k] = 0; iv[k] = 0; ordy[k] = 0; id[k] = 0;
        end
        step();
        step();
        reset = 0;
        #1;
        chk("reset_valid", 32'(ov[0]), 0);
        chk("reset_value", aval[0], 0);
        chk("reset_ready", 32'(rdy[0]), 1);
        ordy[0] = 1;
        key(0, 4);
        key(0, 7);
        iv[0] = 0;
        #1;
        chk("t1_valid", 32'(ov[0]), 1);
        chk("t1_value", aval[0], 47);
        chk("t1_bcd", abcd[0], 32'h47);
        chk("t1_error", 32'(oe[0]), 0);
        step();
        #1;
        chk("t1_consumed", 32'(ov[0]), 0);
        chk("t1_count", acnt[0], 0);
        ordy[0] = 0;
        key(0, 3);
        key(0, 8'h0B);
        #1;
        chk("t2_error", 32'(oe[0]), 1);
        chk("t2_value", aval[0], 3);
        chk("t2_bcd", abcd[0], 32'h03);
        chk("t2_ready", 32'(rdy[0]), 0);
        step();
        step();
        iv[0] = 0;
        ordy[0] = 1;
        step();
        ordy[0] = 0;
        #1;
        chk("t2_consumed", 32'(ov[0]), 0);
        key(0, 9);
        key(0, 9);
        for (int i = 0; i < 5; i++) begin
            id[0] = 5;
            #1;
            chk("t3_hold_value", aval[0], 99);
            chk("t3_hold_ready", 32'(rdy[0]), 0);
            step();
        end
        iv[0] = 0;
        ordy[0] = 1;
        step();
        ordy[0] = 0;
        #1;
        chk("t3_consumed", 32'(ov[0]), 0);
        key(0, 5);
        id[0] = 6;
        cl[0] = 1;
        #1;
        chk("t4_clear_ready", 32'(rdy[0]), 0);
        step();
        cl[0] = 0;
        iv[0] = 0;
        #1;
        chk("t4_count", acnt[0], 0);
        ordy[0] = 1;
        key(0, 1);
        key(0, 2);
        iv[0] = 0;
        #1;
        chk("t4_value", aval[0], 12);
        step();
        ordy[0] = 0;
        key(0, 3);
        key(0, 3);
        iv[0] = 0;
        cl[0] = 1;
        ordy[0] = 1;
        step();
        cl[0] = 0;
        ordy[0] = 0;
        key(0, 8);
        key(0, 1);
        iv[0] = 0;
        #1;
        chk("t5_done", 32'(ov[0]), 1);
        reset = 1;
        #1;
        chk("t5_async_valid", 32'(ov[0]), 0);
        chk("t5_async_value", aval[0], 0);
        chk("t5_async_bcd", abcd[0], 0);
        step();
        reset = 0;
        #1;
        chk("t5_ready", 32'(rdy[0]), 1);
        ordy[1] = 1;
        key(1, 9);
        key(1, 0);
        key(1, 0);
        key(1, 9);
        iv[1] = 0;
        #1;
        chk("t6_value", aval[1], 9009);
        chk("t6_bcd", abcd[1], 32'h9009);
        step();
        ordy[1] = 0;
        key(1, 8'hFF);
        iv[1] = 0;
        #1;
        chk("t6_error", 32'(oe[1]), 1);
        chk("t6_err_value", aval[1], 0);
        ordy[1] = 1;
        step();
        ordy[1] = 0;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
